// File: rtl/uart_rx_circular_buffer.sv
// Byte-wide circular receive buffer between UART RX and MMIO, oldest byte shown first-word-fall-through.
// Define UART_RX_BUF_OVERRUN_CNT_EN to build the saturating dropped-byte counter on overrun_count.
module uart_rx_circular_buffer #(
   parameter int DEPTH_LOG2 = 6
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   input  logic                  rd_en,
   input  logic                  flush,
   input  logic                  overrun_clr,
   output logic [7:0]            rd_data,
   output logic                  empty,
   output logic                  full,
   output logic [DEPTH_LOG2:0]   level,
   output logic                  overrun,
   output logic [7:0]            overrun_count
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
   localparam logic [DEPTH_LOG2:0]   LVL_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
   localparam logic [DEPTH_LOG2:0]   LVL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2:0]   level_q;
   logic                  overrun_q;
   logic                  rd_accept;
   logic                  wr_accept;
   logic                  ovf_evt;

   always_comb begin
      empty     = (level_q == '0);
      full      = (level_q == LVL_FULL);
      level     = level_q;
      overrun   = overrun_q;
      rd_data   = mem[rd_ptr];
      rd_accept = rd_en && !empty && !flush;
      // A pop in the same cycle frees the slot, so a push at full still succeeds.
      wr_accept = rx_valid && (!full || rd_accept) && !flush;
      ovf_evt   = rx_valid && full && !rd_accept && !flush;
   end

   // Storage is intentionally not reset; writes are blocked while reset is asserted.
   always_ff @(posedge clk) begin
      if (resetn && wr_accept)
         mem[wr_ptr] <= rx_data;
   end

   always_ff @(posedge clk) begin
      if (!resetn || flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
      end else begin
         if (wr_accept)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_accept)
            rd_ptr <= rd_ptr + PTR_ONE;
         if (wr_accept && !rd_accept)
            level_q <= level_q + LVL_ONE;
         else if (rd_accept && !wr_accept)
            level_q <= level_q - LVL_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn)
         overrun_q <= 1'b0;
      else if (ovf_evt)
         overrun_q <= 1'b1;
      else if (overrun_clr)
         overrun_q <= 1'b0;
   end

`ifdef UART_RX_BUF_OVERRUN_CNT_EN
   logic [7:0] cnt_q;

   // New event wins over a coincident clear and restarts the count at 1.
   always_ff @(posedge clk) begin
      if (!resetn)
         cnt_q <= '0;
      else if (ovf_evt) begin
         if (overrun_clr)
            cnt_q <= 8'd1;
         else if (cnt_q != '1)
            cnt_q <= cnt_q + 8'd1;
      end else if (overrun_clr)
         cnt_q <= '0;
   end

   assign overrun_count = cnt_q;
`else
   assign overrun_count = '0;
`endif

endmodule
